// File: rtl/vga_display_ctrl.sv
// VGA text-path sequencer: frame-latches the BCD fields on v_sync fall and
// runs the edit-mode FSM, the field-cursor blink and the ring flash.
//
// state      | meaning
// NORMAL     | display only, all fields visible
// EDIT_HORA  | cursor walks hora/min/seg, selected field blinks
// EDIT_FECHA | cursor walks dia/mes/ano, selected field blinks
// EDIT_CRONO | cursor walks c_hora/c_min/c_seg, selected field blinks
module vga_display_ctrl #(
    parameter int BLINK_FRAMES = 15,
    parameter int RING_FRAMES  = 8
) (
    input  logic       CLK_TB,
    input  logic       RESET_TB,
    input  logic       v_sync,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       ring_req,
    input  logic [7:0] hora_in,
    input  logic [7:0] min_in,
    input  logic [7:0] seg_in,
    input  logic [7:0] dia_in,
    input  logic [7:0] mes_in,
    input  logic [7:0] ano_in,
    input  logic [7:0] c_hora_in,
    input  logic [7:0] c_min_in,
    input  logic [7:0] c_seg_in,
    output logic [7:0] hora,
    output logic [7:0] min,
    output logic [7:0] seg,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] ano,
    output logic [7:0] c_hora,
    output logic [7:0] c_min,
    output logic [7:0] c_seg,
    output logic       bandera_hh,
    output logic       bandera_mh,
    output logic       bandera_sh,
    output logic       bandera_df,
    output logic       bandera_mf,
    output logic       bandera_af,
    output logic       bandera_hc,
    output logic       bandera_mc,
    output logic       bandera_sc,
    output logic       activring,
    output logic [1:0] edit_mode,
    output logic [1:0] cursor
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int RW = (RING_FRAMES > 1) ? $clog2(RING_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_FRAMES - 1);

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        EDIT_HORA  = 2'd1,
        EDIT_FECHA = 2'd2,
        EDIT_CRONO = 2'd3
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [1:0]     cursor_q, cursor_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           blink_phase_q, blink_phase_d;
    logic [RW-1:0]  ring_cnt_q, ring_cnt_d;
    logic           ring_req_q, ring_req_d;
    logic           activring_q, activring_d;
    logic           v_sync_q, v_sync_d;
    logic [71:0]    fields_q, fields_d;
    logic [8:0]     flags_q, flags_d;
    logic [2:0]     grp_flags;
    logic           frame_tick;

    assign frame_tick = v_sync_q & ~v_sync;

    always_comb begin
        mode_d        = mode_q;
        cursor_d      = cursor_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        ring_cnt_d    = ring_cnt_q;
        activring_d   = activring_q;
        ring_req_d    = ring_req;
        v_sync_d      = v_sync;
        fields_d      = fields_q;

        if (frame_tick) begin
            fields_d = {hora_in, min_in, seg_in, dia_in, mes_in, ano_in,
                        c_hora_in, c_min_in, c_seg_in};
        end

        // Button blink restart takes priority over a coincident frame tick.
        if (btn_mode) begin
            mode_d        = mode_e'(mode_q + 2'd1);
            cursor_d      = 2'd0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (btn_next && (mode_q != NORMAL)) begin
            cursor_d      = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (mode_q == NORMAL) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        if (!ring_req) begin
            activring_d = 1'b0;
            ring_cnt_d  = '0;
        end else if (!ring_req_q) begin
            activring_d = 1'b1;
            ring_cnt_d  = '0;
        end else if (frame_tick) begin
            if (ring_cnt_q == RING_LAST) begin
                ring_cnt_d  = '0;
                activring_d = ~activring_q;
            end else begin
                ring_cnt_d = ring_cnt_q + RW'(1);
            end
        end

        // Flags follow the next state so they move on the same edge as mode/cursor.
        grp_flags = 3'b111;
        grp_flags[2'd2 - cursor_d] = blink_phase_d;
        flags_d = 9'h1ff;
        case (mode_d)
            EDIT_HORA:  flags_d[8:6] = grp_flags;
            EDIT_FECHA: flags_d[5:3] = grp_flags;
            EDIT_CRONO: flags_d[2:0] = grp_flags;
            default:    flags_d      = 9'h1ff;
        endcase
    end

    always_ff @(posedge CLK_TB) begin
        if (RESET_TB) begin
            mode_q        <= NORMAL;
            cursor_q      <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            ring_cnt_q    <= '0;
            ring_req_q    <= 1'b0;
            activring_q   <= 1'b0;
            v_sync_q      <= 1'b1;
            fields_q      <= '0;
            flags_q       <= 9'h1ff;
        end else begin
            mode_q        <= mode_d;
            cursor_q      <= cursor_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            ring_cnt_q    <= ring_cnt_d;
            ring_req_q    <= ring_req_d;
            activring_q   <= activring_d;
            v_sync_q      <= v_sync_d;
            fields_q      <= fields_d;
            flags_q       <= flags_d;
        end
    end

    assign {hora, min, seg, dia, mes, ano, c_hora, c_min, c_seg} = fields_q;
    assign {bandera_hh, bandera_mh, bandera_sh,
            bandera_df, bandera_mf, bandera_af,
            bandera_hc, bandera_mc, bandera_sc} = flags_q;
    assign activring = activring_q;
    assign edit_mode = mode_q;
    assign cursor    = cursor_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Scoreboard bench for vga_display_ctrl: a cycle model pushes expected outputs
// before each edge, and they are popped and compared just after it.
module tb_vga_display_ctrl;

    localparam int BLINK = 2;
    localparam int RING  = 2;

    logic       CLK_TB = 1'b0;
    logic       RESET_TB = 1'b1;
    logic       v_sync = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       ring_req = 1'b0;
    logic [7:0] in_f [9];
    logic [7:0] hora, min, seg, dia, mes, ano, c_hora, c_min, c_seg;
    logic       bandera_hh, bandera_mh, bandera_sh, bandera_df, bandera_mf;
    logic       bandera_af, bandera_hc, bandera_mc, bandera_sc;
    logic       activring;
    logic [1:0] edit_mode, cursor;

    always #5 CLK_TB = ~CLK_TB;

    vga_display_ctrl #(.BLINK_FRAMES(BLINK), .RING_FRAMES(RING)) dut (
        .CLK_TB(CLK_TB), .RESET_TB(RESET_TB), .v_sync(v_sync),
        .btn_mode(btn_mode), .btn_next(btn_next), .ring_req(ring_req),
        .hora_in(in_f[0]), .min_in(in_f[1]), .seg_in(in_f[2]),
        .dia_in(in_f[3]), .mes_in(in_f[4]), .ano_in(in_f[5]),
        .c_hora_in(in_f[6]), .c_min_in(in_f[7]), .c_seg_in(in_f[8]),
        .hora(hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .ano(ano),
        .c_hora(c_hora), .c_min(c_min), .c_seg(c_seg),
        .bandera_hh(bandera_hh), .bandera_mh(bandera_mh), .bandera_sh(bandera_sh),
        .bandera_df(bandera_df), .bandera_mf(bandera_mf), .bandera_af(bandera_af),
        .bandera_hc(bandera_hc), .bandera_mc(bandera_mc), .bandera_sc(bandera_sc),
        .activring(activring), .edit_mode(edit_mode), .cursor(cursor)
    );

    typedef struct {
        logic [71:0] fld;
        logic [8:0]  flg;
        logic        act;
        logic [1:0]  mode;
        logic [1:0]  cur;
    } exp_t;

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [71:0] m_fld;
    int          m_mode, m_cur, m_bc, m_rc;
    logic        m_ph, m_act, m_rprev, m_vs_d;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [71:0] dut_fields();
        return {hora, min, seg, dia, mes, ano, c_hora, c_min, c_seg};
    endfunction

    function automatic logic [8:0] dut_flags();
        return {bandera_hh, bandera_mh, bandera_sh, bandera_df, bandera_mf,
                bandera_af, bandera_hc, bandera_mc, bandera_sc};
    endfunction

    task automatic model_step();
        logic ft;
        exp_t e;
        ft = m_vs_d & ~v_sync;
        if (RESET_TB) begin
            m_fld = '0; m_mode = 0; m_cur = 0; m_bc = 0; m_ph = 1'b1;
            m_rc = 0; m_act = 1'b0; m_rprev = 1'b0; m_vs_d = 1'b1;
        end else begin
            if (ft) m_fld = {in_f[0], in_f[1], in_f[2], in_f[3], in_f[4],
                             in_f[5], in_f[6], in_f[7], in_f[8]};
            if (btn_mode) begin
                m_mode = (m_mode + 1) % 4; m_cur = 0; m_bc = 0; m_ph = 1'b1;
            end else if (btn_next && m_mode != 0) begin
                m_cur = (m_cur + 1) % 3; m_bc = 0; m_ph = 1'b1;
            end else if (m_mode == 0) begin
                m_bc = 0; m_ph = 1'b1;
            end else if (ft) begin
                m_bc++;
                if (m_bc == BLINK) begin m_bc = 0; m_ph = ~m_ph; end
            end
            if (!ring_req) begin
                m_act = 1'b0; m_rc = 0;
            end else if (!m_rprev) begin
                m_act = 1'b1; m_rc = 0;
            end else if (ft) begin
                m_rc++;
                if (m_rc == RING) begin m_rc = 0; m_act = ~m_act; end
            end
            m_rprev = ring_req;
            m_vs_d = v_sync;
        end
        e.fld  = m_fld;
        e.flg  = 9'h1ff;
        if (m_mode != 0) e.flg[8 - ((m_mode - 1) * 3 + m_cur)] = m_ph;
        e.act  = m_act;
        e.mode = 2'(m_mode);
        e.cur  = 2'(m_cur);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge CLK_TB);
        #1;
        e = sb_q.pop_front();
        chk("fields", dut_fields(), e.fld);
        chk("flags", {63'd0, dut_flags()}, {63'd0, e.flg});
        chk("activring", {71'd0, activring}, {71'd0, e.act});
        chk("edit_mode", {70'd0, edit_mode}, {70'd0, e.mode});
        chk("cursor", {70'd0, cursor}, {70'd0, e.cur});
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    endtask

    task automatic pulse_next();
        btn_next = 1'b1; tick(); btn_next = 1'b0;
    endtask

    task automatic frame();
        v_sync = 1'b0; tick(); tick();
        v_sync = 1'b1; repeat (4) tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_fields"}, dut_fields(), 72'd0);
        chk({tag, "_flags"}, {63'd0, dut_flags()}, {63'd0, 9'h1ff});
        chk({tag, "_act"}, {71'd0, activring}, 72'd0);
        chk({tag, "_mode"}, {70'd0, edit_mode}, 72'd0);
        chk({tag, "_cur"}, {70'd0, cursor}, 72'd0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) in_f[i] = 8'h00;

        // reset held 3 clocks with btn_mode toggling
        for (int i = 0; i < 3; i++) begin
            btn_mode = i[0] ? 1'b0 : 1'b1;
            tick();
        end
        btn_mode = 1'b0;
        chk_reset_state("reset");
        RESET_TB = 1'b0;
        tick();

        // snapshot: latched on first falling edge only, even with a long low pulse
        in_f[0] = 8'h12; in_f[1] = 8'h34;
        repeat (3) tick();
        chk("hora_pre", {64'd0, hora}, {64'd0, 8'h00});
        v_sync = 1'b0;
        tick();
        chk("hora_snap", {64'd0, hora}, {64'd0, 8'h12});
        chk("min_snap", {64'd0, min}, {64'd0, 8'h34});
        in_f[0] = 8'h56;
        repeat (99) tick();
        chk("hora_hold_low", {64'd0, hora}, {64'd0, 8'h12});
        v_sync = 1'b1;
        repeat (3) tick();
        chk("hora_after_low", {64'd0, hora}, {64'd0, 8'h12});
        frame();
        chk("hora_next_frame", {64'd0, hora}, {64'd0, 8'h56});

        // edit walk in EDIT_HORA, middle field blinks 2 on / 2 off
        pulse_mode();
        pulse_next();
        chk("walk_mode", {70'd0, edit_mode}, {70'd0, 2'd1});
        chk("walk_cur", {70'd0, cursor}, {70'd0, 2'd1});
        frame(); frame();
        chk("mh_off", {71'd0, bandera_mh}, 72'd0);
        frame(); frame();
        chk("mh_on", {71'd0, bandera_mh}, 72'd1);
        frame(); frame();
        pulse_next(); pulse_next();
        chk("cur_wrap", {70'd0, cursor}, 72'd0);
        frame(); frame();
        chk("hh_off", {71'd0, bandera_hh}, 72'd0);

        // mode wrap back to NORMAL, then mode/next collision from mode 3 cursor 2
        pulse_mode(); pulse_mode(); pulse_mode();
        chk("wrap_mode", {70'd0, edit_mode}, 72'd0);
        frame();
        repeat (3) pulse_mode();
        pulse_next(); pulse_next();
        frame();
        btn_mode = 1'b1; btn_next = 1'b1; tick();
        btn_mode = 1'b0; btn_next = 1'b0;
        chk("coll_mode", {70'd0, edit_mode}, 72'd0);
        chk("coll_cur", {70'd0, cursor}, 72'd0);

        // ring flash in EDIT_FECHA
        pulse_mode(); pulse_mode();
        ring_req = 1'b1; tick();
        chk("ring_on", {71'd0, activring}, 72'd1);
        frame(); frame();
        chk("ring_off", {71'd0, activring}, 72'd0);
        frame(); frame();
        chk("ring_on2", {71'd0, activring}, 72'd1);
        frame();
        ring_req = 1'b0; tick();
        chk("ring_drop", {71'd0, activring}, 72'd0);

        // reset mid-edit with a blanked field and the ring active
        pulse_next();
        ring_req = 1'b1;
        frame(); frame();
        chk("pre_rst_mf", {71'd0, bandera_mf}, 72'd0);
        RESET_TB = 1'b1; tick();
        RESET_TB = 1'b0;
        chk_reset_state("midop");
        ring_req = 1'b0;
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            btn_mode = ($urandom_range(0, 15) == 0);
            btn_next = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) v_sync = ~v_sync;
            if ($urandom_range(0, 40) == 0) ring_req = ~ring_req;
            if ($urandom_range(0, 7) == 0) in_f[$urandom_range(0, 8)] = 8'($urandom);
            RESET_TB = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
